// File: rtl/seg_note_decoder.sv
// Seven-segment note-glyph capture: two-flop sync, stability filter, and decode back to {tom, notas}.
// Used on the readback/loop-back side of the note display path.
module seg_note_decoder #(
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned CNT_W         = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] seg_in,
   output logic       tom,
   output logic [2:0] notas,
   output logic       valid,
   output logic       invalid,
   output logic       locked
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

   typedef enum logic {
      SETTLE,
      HOLD
   } state_t;

   state_t           state;
   logic [6:0]       s1;
   logic [6:0]       s2;
   logic [6:0]       last_seg;
   logic             first_done;
   logic [CNT_W-1:0] cnt;
   logic             same;
   logic [6:0]       key;
   logic             dec_ok;
   logic [3:0]       dec_code;

   // s1 holds the sample about to enter s2, so s1==s2 means the next s2 equals the current one.
   assign same = (s1 == s2);

   // Glyph lookup keyed in s1..s7 order so the table reads like the panel strings.
   assign key = {s2[0], s2[1], s2[2], s2[3], s2[4], s2[5], s2[6]};

   always_comb begin
      dec_ok   = 1'b1;
      dec_code = 4'h0;
      case (key)
         7'b1111111: dec_code = 4'h0;
         7'b0101010: dec_code = 4'h1;
         7'b0001001: dec_code = 4'h2;
         7'b0001011: dec_code = 4'h3;
         7'b0110110: dec_code = 4'h4;
         7'b0101001: dec_code = 4'h5;
         7'b0001100: dec_code = 4'h6;
         7'b0011100: dec_code = 4'h7;
         7'b1110111: dec_code = 4'h8;
         7'b1110010: dec_code = 4'h9; // also the glyph of code 1011; always read as 1001
         7'b1000010: dec_code = 4'hA;
         7'b1110100: dec_code = 4'hC;
         7'b1010001: dec_code = 4'hD;
         7'b1001110: dec_code = 4'hE;
         7'b1010100: dec_code = 4'hF;
         default:    dec_ok   = 1'b0;
      endcase
   end

   // Two-flop synchroniser for the asynchronous segment bus.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1 <= 7'h00;
         s2 <= 7'h00;
      end else begin
         s1 <= seg_in;
         s2 <= s1;
      end
   end

   // Stability counter: restarts on any change, saturates at the acceptance threshold.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (!same) begin
         cnt <= '0;
      end else if (cnt < CNT_MAX) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Accept/lock FSM with registered decode outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= SETTLE;
         tom        <= 1'b0;
         notas      <= 3'b000;
         valid      <= 1'b0;
         invalid    <= 1'b0;
         locked     <= 1'b0;
         last_seg   <= 7'h7F;
         first_done <= 1'b0;
      end else begin
         valid <= 1'b0;
         case (state)
            SETTLE: begin
               if (same && (cnt == CNT_MAX)) begin
                  state   <= HOLD;
                  locked  <= 1'b1;
                  invalid <= !dec_ok;
                  if (dec_ok) begin
                     tom   <= dec_code[3];
                     notas <= dec_code[2:0];
                  end
                  // first_done makes the first accept after reset report even a 1111111 glyph.
                  if (!first_done || (s2 != last_seg)) begin
                     valid <= 1'b1;
                  end
                  last_seg   <= s2;
                  first_done <= 1'b1;
               end
            end
            HOLD: begin
               if (!same) begin
                  state  <= SETTLE;
                  locked <= 1'b0;
               end
            end
            default: state <= SETTLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seg_note_decoder.sv
// Randomised scoreboard bench for seg_note_decoder against a run-length reference model.
module tb_seg_note_decoder;

   localparam int unsigned STABLE = 4;
   localparam int DEPTH = 16384;

   logic       clk;
   logic       reset;
   logic [6:0] seg_in;
   logic       tom;
   logic [2:0] notas;
   logic       valid;
   logic       invalid;
   logic       locked;

   seg_note_decoder #(.STABLE_CYCLES(STABLE), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .seg_in(seg_in), .tom(tom), .notas(notas),
      .valid(valid), .invalid(invalid), .locked(locked)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         edge_n;
      logic [3:0] code;
      logic       inv;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;

   int errors = 0;
   int checks = 0;
   int edge_cnt = 0;

   bit         exp_set  [DEPTH];
   logic       exp_lock [DEPTH];
   logic [3:0] exp_code [DEPTH];
   logic       exp_inv  [DEPTH];

   // Glyph table in panel string order (leftmost char = s1 = seg_in[0]).
   logic [6:0] gl [15] = '{7'b1111111, 7'b0101010, 7'b0001001, 7'b0001011, 7'b0110110,
                           7'b0101001, 7'b0001100, 7'b0011100, 7'b1110111, 7'b1110010,
                           7'b1000010, 7'b1110100, 7'b1010001, 7'b1001110, 7'b1010100};
   logic [3:0] gc [15] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
                           4'h8, 4'h9, 4'hA, 4'hC, 4'hD, 4'hE, 4'hF};

   // Reference model state
   int         run;
   bit         have_prev;
   logic [6:0] prev_g;
   bit         have_acc;
   logic [6:0] last_acc;
   logic [3:0] cur_code;
   logic       cur_inv;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_cnt, act, req);
      end
   endtask

   function automatic logic [6:0] to_seg(input logic [6:0] g);
      logic [6:0] s;
      for (int i = 0; i < 7; i++) s[i] = g[6-i];
      return s;
   endfunction

   function automatic bit lookup(input logic [6:0] g, output logic [3:0] c);
      c = 4'h0;
      for (int i = 0; i < 15; i++) begin
         if (gl[i] == g) begin
            c = gc[i];
            return 1'b1;
         end
      end
      return 1'b0;
   endfunction

   task automatic set_exp(input int e, input logic lk, input logic [3:0] c, input logic inv);
      if (e < DEPTH) begin
         exp_set[e]  = 1'b1;
         exp_lock[e] = lk;
         exp_code[e] = c;
         exp_inv[e]  = inv;
      end
   endtask

   // A glyph sampled identically on STABLE+1 consecutive edges is accepted on the following edge.
   task automatic model_step(input int j, input bit rst, input logic [6:0] g);
      logic [3:0] c;
      bit ok;
      exp_t e;
      if (rst) begin
         run = 0; have_prev = 0; have_acc = 0; cur_code = 4'h0; cur_inv = 1'b0;
         while (sbq.size() > 0 && sbq[$].edge_n >= j) void'(sbq.pop_back());
         set_exp(j, 1'b0, 4'h0, 1'b0);
         set_exp(j + 1, 1'b0, 4'h0, 1'b0);
         return;
      end
      run = (have_prev && g == prev_g) ? run + 1 : 1;
      prev_g = g;
      have_prev = 1;
      if (run == int'(STABLE) + 1) begin
         ok = lookup(g, c);
         if (ok) cur_code = c;
         cur_inv = !ok;
         if (!have_acc || g != last_acc) begin
            e.edge_n = j + 1; e.code = cur_code; e.inv = cur_inv;
            sbq.push_back(e);
         end
         last_acc = g;
         have_acc = 1;
      end
      set_exp(j + 1, run >= int'(STABLE) + 1, cur_code, cur_inv);
   endtask

   task automatic drive(input logic [6:0] g, input bit rst, input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         reset  = rst;
         seg_in = to_seg(g);
         model_step(edge_cnt + 1, rst, g);
      end
   endtask

   // Monitor: level checks every edge, valid pulses popped from the scoreboard.
   always @(posedge clk) begin
      edge_cnt++;
      #1;
      if (edge_cnt < DEPTH && exp_set[edge_cnt]) begin
         check("locked", int'(locked), int'(exp_lock[edge_cnt]));
         check("code", int'({tom, notas}), int'(exp_code[edge_cnt]));
         check("invalid", int'(invalid), int'(exp_inv[edge_cnt]));
      end
      while (sbq.size() > 0 && sbq[0].edge_n < edge_cnt) begin
         check("missed_valid", 0, 1);
         void'(sbq.pop_front());
      end
      if (valid === 1'b1) begin
         if (sbq.size() == 0) begin
            check("spurious_valid", 1, 0);
         end else begin
            mon_e = sbq.pop_front();
            check("valid_edge", edge_cnt, mon_e.edge_n);
            check("valid_code", int'({tom, notas}), int'(mon_e.code));
            check("valid_inv", int'(invalid), int'(mon_e.inv));
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: timeout at edge %0d, expected finish", edge_cnt);
      $fatal(1, "timeout");
   end

   initial begin
      logic [6:0] g;
      reset = 1'b1;
      seg_in = 7'h7F;
      run = 0; have_prev = 0; have_acc = 0; prev_g = '0; last_acc = '0;
      cur_code = 4'h0; cur_inv = 1'b0;

      drive(7'b1111111, 1, 3);
      drive(7'b1111111, 0, 10);
      for (int i = 0; i < 15; i++) drive(gl[i], 0, 10);
      // Short excursion never settles
      drive(7'b0101001, 0, 10);
      drive(7'b0001100, 0, 3);
      drive(7'b0101001, 0, 10);
      // Unknown pattern then recovery
      drive(7'b0000000, 0, 10);
      drive(7'b0011100, 0, 10);
      // Bounce and return to the same glyph
      drive(7'b1010001, 0, 10);
      drive(7'b0000000, 0, 2);
      drive(7'b1010001, 0, 10);
      // Reset while settling, then while locked
      drive(7'b0110110, 0, 3);
      drive(7'b1111111, 1, 1);
      drive(7'b1111111, 0, 10);
      drive(7'b1110111, 0, 10);
      drive(7'b1111111, 1, 2);
      drive(7'b1111111, 0, 10);
      // Random glyph stream with random hold times
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 9) < 7) g = gl[$urandom_range(0, 14)];
         else g = 7'($urandom);
         drive(g, 0, $urandom_range(1, 8));
      end
      drive(7'b1010100, 0, 12);
      check("queue_drained", sbq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
